// File: rtl/sargantana_icache_pkg.sv
// Shared sizing and types for the instruction-cache memory controller.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_N_WAY  = 4;
  localparam int unsigned ICACHE_IDX_W  = 6;
  localparam int unsigned ICACHE_TAG_W  = 20;
  localparam int unsigned ICACHE_LINE_W = 128;
  localparam int unsigned ICACHE_SETS   = 1 << ICACHE_IDX_W;

  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_hit_sel.sv
// Tag match across ways, lowest-index winner, and line select for that way.
module sargantana_icache_hit_sel #(
  parameter int unsigned N_WAY  = 4,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned LINE_W = 128
) (
  input  logic [N_WAY*TAG_W-1:0]  tags_i,
  input  logic [N_WAY*LINE_W-1:0] lines_i,
  input  logic [N_WAY-1:0]        vbit_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    hit_o,
  output logic [N_WAY-1:0]        way_o,
  output logic [LINE_W-1:0]       line_o
);

  logic [N_WAY-1:0] hit_vec;

  // Descending scan so the lowest matching way is the last one written.
  always_comb begin
    hit_vec = '0;
    way_o   = '0;
    line_o  = '0;
    for (int w = 0; w < int'(N_WAY); w++) begin
      hit_vec[w] = vbit_i[w] && (tags_i[w*TAG_W +: TAG_W] == tag_i);
    end
    for (int w = int'(N_WAY) - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        way_o    = '0;
        way_o[w] = 1'b1;
        line_o   = lines_i[w*LINE_W +: LINE_W];
      end
    end
  end

  assign hit_o = |hit_vec;

endmodule

// File: rtl/sargantana_icache_mem_ctrl.sv
// Arbitrates flush sweep, refill writes and lookup reads onto the icache
// tag/data memories, and resolves lookup hits one cycle after grant.
module sargantana_icache_mem_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_WAY  = ICACHE_N_WAY,
  parameter int unsigned IDX_W  = ICACHE_IDX_W,
  parameter int unsigned TAG_W  = ICACHE_TAG_W,
  parameter int unsigned LINE_W = ICACHE_LINE_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    busy_o,
  input  logic                    lkp_req_i,
  input  logic [IDX_W-1:0]        lkp_idx_i,
  input  logic [TAG_W-1:0]        lkp_tag_i,
  output logic                    lkp_gnt_o,
  output logic                    rsp_valid_o,
  output logic                    rsp_hit_o,
  output logic [N_WAY-1:0]        rsp_way_o,
  output logic [LINE_W-1:0]       rsp_line_o,
  input  logic                    rfl_req_i,
  input  logic [IDX_W-1:0]        rfl_idx_i,
  input  logic [TAG_W-1:0]        rfl_tag_i,
  input  logic [N_WAY-1:0]        rfl_way_i,
  input  logic [LINE_W-1:0]       rfl_line_i,
  output logic                    rfl_gnt_o,
  output logic [N_WAY-1:0]        mem_tag_req_o,
  output logic [N_WAY-1:0]        mem_data_req_o,
  output logic                    mem_tag_we_o,
  output logic                    mem_data_we_o,
  output logic                    mem_flush_o,
  output logic                    mem_vbit_o,
  output logic [IDX_W-1:0]        mem_addr_o,
  output logic [TAG_W-1:0]        mem_tag_o,
  output logic [LINE_W-1:0]       mem_line_o,
  input  logic [N_WAY*TAG_W-1:0]  mem_tag_way_i,
  input  logic [N_WAY*LINE_W-1:0] mem_line_way_i,
  input  logic [N_WAY-1:0]        mem_vbit_i
);

  localparam int unsigned SETS = 1 << IDX_W;

  ctrl_state_t       state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q;
  logic [TAG_W-1:0]  lkp_tag_q;

  logic              hit_c;
  logic [N_WAY-1:0]  way_c;
  logic [LINE_W-1:0] line_c;

  // Next state and memory-port drive; everything is quiet while rst_i is high.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_o         = 1'b0;
    flush_done_o   = 1'b0;
    lkp_gnt_o      = 1'b0;
    rfl_gnt_o      = 1'b0;
    mem_tag_req_o  = '0;
    mem_data_req_o = '0;
    mem_tag_we_o   = 1'b0;
    mem_data_we_o  = 1'b0;
    mem_flush_o    = 1'b0;
    mem_vbit_o     = 1'b0;
    mem_addr_o     = '0;
    mem_tag_o      = '0;
    mem_line_o     = '0;
    if (!rst_i) begin
      case (state_q)
        FLUSH: begin
          busy_o        = 1'b1;
          mem_tag_req_o = '1;
          mem_tag_we_o  = 1'b1;
          mem_flush_o   = 1'b1;
          mem_addr_o    = cnt_q;
          cnt_d         = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(SETS - 1)) begin
            state_d      = IDLE;
            flush_done_o = 1'b1;
          end
        end
        IDLE: begin
          if (flush_i) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else if (rfl_req_i) begin
            rfl_gnt_o      = 1'b1;
            mem_tag_req_o  = rfl_way_i;
            mem_data_req_o = rfl_way_i;
            mem_tag_we_o   = 1'b1;
            mem_data_we_o  = 1'b1;
            mem_vbit_o     = 1'b1;
            mem_addr_o     = rfl_idx_i;
            mem_tag_o      = rfl_tag_i;
            mem_line_o     = rfl_line_i;
          end else if (lkp_req_i) begin
            lkp_gnt_o      = 1'b1;
            mem_tag_req_o  = '1;
            mem_data_req_o = '1;
            mem_addr_o     = lkp_idx_i;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      lkp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= lkp_gnt_o;
      if (lkp_gnt_o) lkp_tag_q <= lkp_tag_i;
    end
  end

  sargantana_icache_hit_sel #(
    .N_WAY  (N_WAY),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_hit_sel (
    .tags_i  (mem_tag_way_i),
    .lines_i (mem_line_way_i),
    .vbit_i  (mem_vbit_i),
    .tag_i   (lkp_tag_q),
    .hit_o   (hit_c),
    .way_o   (way_c),
    .line_o  (line_c)
  );

  // Memory read data arrives the cycle after grant; gate it with the pending flag.
  assign rsp_valid_o = rsp_valid_q & ~rst_i;
  assign rsp_hit_o   = rsp_valid_o & hit_c;
  assign rsp_way_o   = rsp_valid_o ? way_c  : '0;
  assign rsp_line_o  = rsp_valid_o ? line_c : '0;

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// Scoreboard bench: SRAM environment model, cache-contents reference model, directed and random traffic.
module tb_sargantana_icache_mem_ctrl;
  import sargantana_icache_pkg::*;

  localparam int NW = ICACHE_N_WAY;
  localparam int IW = ICACHE_IDX_W;
  localparam int TW = ICACHE_TAG_W;
  localparam int LW = ICACHE_LINE_W;
  localparam int NS = ICACHE_SETS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, flush = 1'b0;
  logic          lkp_req = 1'b0, rfl_req = 1'b0;
  logic [IW-1:0] lkp_idx = '0, rfl_idx = '0;
  logic [TW-1:0] lkp_tag = '0, rfl_tag = '0;
  logic [NW-1:0] rfl_way = '0;
  logic [LW-1:0] rfl_line = '0;

  logic flush_done_o, busy_o, lkp_gnt_o, rsp_valid_o, rsp_hit_o, rfl_gnt_o;
  logic [NW-1:0] rsp_way_o, mem_tag_req_o, mem_data_req_o;
  logic [LW-1:0] rsp_line_o, mem_line_o;
  logic mem_tag_we_o, mem_data_we_o, mem_flush_o, mem_vbit_o;
  logic [IW-1:0] mem_addr_o;
  logic [TW-1:0] mem_tag_o;
  logic [NW*TW-1:0] mem_tag_way;
  logic [NW*LW-1:0] mem_line_way;
  logic [NW-1:0]    mem_vbit_rd;

  sargantana_icache_mem_ctrl dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_done_o(flush_done_o), .busy_o(busy_o),
    .lkp_req_i(lkp_req), .lkp_idx_i(lkp_idx), .lkp_tag_i(lkp_tag), .lkp_gnt_o(lkp_gnt_o),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_way_o(rsp_way_o), .rsp_line_o(rsp_line_o),
    .rfl_req_i(rfl_req), .rfl_idx_i(rfl_idx), .rfl_tag_i(rfl_tag), .rfl_way_i(rfl_way),
    .rfl_line_i(rfl_line), .rfl_gnt_o(rfl_gnt_o),
    .mem_tag_req_o(mem_tag_req_o), .mem_data_req_o(mem_data_req_o),
    .mem_tag_we_o(mem_tag_we_o), .mem_data_we_o(mem_data_we_o), .mem_flush_o(mem_flush_o),
    .mem_vbit_o(mem_vbit_o), .mem_addr_o(mem_addr_o), .mem_tag_o(mem_tag_o), .mem_line_o(mem_line_o),
    .mem_tag_way_i(mem_tag_way), .mem_line_way_i(mem_line_way), .mem_vbit_i(mem_vbit_rd)
  );

  // ---------------- SRAM environment (synchronous read, write-first ordering irrelevant) -------------
  logic [TW-1:0] s_tag  [NW][NS];
  logic [LW-1:0] s_line [NW][NS];
  logic          s_v    [NW][NS];
  logic [TW-1:0] rd_tag [NW];
  logic [LW-1:0] rd_line[NW];
  logic [NW-1:0] rd_v;

  function automatic logic [LW-1:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    for (int w = 0; w < NW; w++) begin
      rd_tag[w] = '0; rd_line[w] = '0;
      for (int s = 0; s < NS; s++) begin
        s_tag[w][s] = TW'($urandom); s_line[w][s] = rline(); s_v[w][s] = 1'($urandom);
      end
    end
    rd_v = '0;
  end

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (mem_tag_req_o[w]) begin
        if (mem_tag_we_o) begin
          s_tag[w][mem_addr_o] <= mem_tag_o;
          s_v[w][mem_addr_o]   <= mem_vbit_o;
        end else begin
          rd_tag[w] <= s_tag[w][mem_addr_o];
          rd_v[w]   <= s_v[w][mem_addr_o];
        end
      end
      if (mem_data_req_o[w]) begin
        if (mem_data_we_o) s_line[w][mem_addr_o] <= mem_line_o;
        else               rd_line[w] <= s_line[w][mem_addr_o];
      end
    end
  end

  always_comb begin
    mem_tag_way  = '0;
    mem_line_way = '0;
    for (int w = 0; w < NW; w++) begin
      mem_tag_way[w*TW +: TW]  = rd_tag[w];
      mem_line_way[w*LW +: LW] = rd_line[w];
    end
    mem_vbit_rd = rd_v;
  end

  // ---------------- Reference model: cache contents + scoreboard ----------------
  typedef struct {
    int            cyc;
    logic          hit;
    logic [NW-1:0] way;
    logic [LW-1:0] line;
  } exp_t;

  exp_t          q[$];
  bit            m_v   [NS][NW];
  logic [TW-1:0] m_tag [NS][NW];
  logic [LW-1:0] m_line[NS][NW];

  int checks = 0, errors = 0;
  int cyc = 0;
  int sweep_k = -1;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t predict(input int idx, input logic [TW-1:0] tag, input int at);
    exp_t e;
    e.cyc = at; e.hit = 1'b0; e.way = '0; e.line = '0;
    for (int w = 0; w < NW; w++) begin
      if (!e.hit && m_v[idx][w] && m_tag[idx][w] == tag) begin
        e.hit = 1'b1; e.way = NW'(1) << w; e.line = m_line[idx][w];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   exp_v;
    cyc++;
    if (rst) begin
      started = 1'b1;
      sweep_k = 0;
      q.delete();
      chk("rst_outs", LW'({busy_o, lkp_gnt_o, rfl_gnt_o, rsp_valid_o, flush_done_o,
                           mem_tag_we_o, mem_data_we_o, mem_flush_o, mem_vbit_o}), '0);
      chk("rst_mem_req", LW'({mem_tag_req_o, mem_data_req_o}), '0);
    end else if (started) begin
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      chk("rsp_valid", LW'(rsp_valid_o), LW'(exp_v));
      if (exp_v) begin
        e = q.pop_front();
        chk("rsp_hit", LW'(rsp_hit_o), LW'(e.hit));
        chk("rsp_way", LW'(rsp_way_o), LW'(e.way));
        chk("rsp_line", rsp_line_o, e.line);
      end
      if (rfl_req) chk("rfl_way_onehot", LW'($onehot(rfl_way)), LW'(1));
      if (sweep_k >= 0) begin
        if (sweep_k == 0)
          for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
        chk("sweep_ctl", LW'({busy_o, mem_tag_we_o, mem_flush_o, mem_vbit_o, mem_data_we_o,
                              lkp_gnt_o, rfl_gnt_o, flush_done_o}),
            LW'({7'b1110000, sweep_k == NS - 1}));
        chk("sweep_addr", LW'(mem_addr_o), LW'(sweep_k));
        chk("sweep_req", LW'({mem_tag_req_o, mem_data_req_o}), LW'({{NW{1'b1}}, {NW{1'b0}}}));
        sweep_k = (sweep_k == NS - 1) ? -1 : sweep_k + 1;
      end else begin
        chk("idle_busy", LW'({busy_o, flush_done_o}), '0);
        if (flush) begin
          chk("flush_start", LW'({lkp_gnt_o, rfl_gnt_o, mem_tag_req_o, mem_data_req_o}), '0);
          sweep_k = 0;
        end else if (rfl_req) begin
          chk("rfl_gnt", LW'({rfl_gnt_o, lkp_gnt_o}), LW'(2'b10));
          chk("rfl_ctl", LW'({mem_tag_req_o, mem_data_req_o, mem_tag_we_o, mem_data_we_o,
                              mem_vbit_o, mem_flush_o, mem_addr_o, mem_tag_o}),
              LW'({rfl_way, rfl_way, 4'b1110, rfl_idx, rfl_tag}));
          chk("rfl_line", mem_line_o, rfl_line);
          for (int w = 0; w < NW; w++)
            if (rfl_way[w]) begin
              m_v[rfl_idx][w] = 1'b1; m_tag[rfl_idx][w] = rfl_tag; m_line[rfl_idx][w] = rfl_line;
            end
        end else if (lkp_req) begin
          chk("lkp_gnt", LW'({rfl_gnt_o, lkp_gnt_o}), LW'(2'b01));
          chk("lkp_ctl", LW'({mem_tag_req_o, mem_data_req_o, mem_tag_we_o, mem_data_we_o,
                              mem_flush_o, mem_addr_o}),
              LW'({{NW{1'b1}}, {NW{1'b1}}, 3'b000, lkp_idx}));
          q.push_back(predict(int'(lkp_idx), lkp_tag, cyc + 1));
        end else begin
          chk("no_req", LW'({lkp_gnt_o, rfl_gnt_o, mem_tag_req_o, mem_data_req_o}), '0);
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic refill(input int idx, input logic [TW-1:0] tag, input logic [NW-1:0] way,
                        input logic [LW-1:0] line);
    rfl_req = 1'b1; rfl_idx = IW'(idx); rfl_tag = tag; rfl_way = way; rfl_line = line;
    step(); rfl_req = 1'b0;
  endtask

  task automatic lookup(input int idx, input logic [TW-1:0] tag);
    lkp_req = 1'b1; lkp_idx = IW'(idx); lkp_tag = tag;
    step(); lkp_req = 1'b0;
  endtask

  task automatic rand_rfl_fields();
    rfl_idx = IW'($urandom_range(0, 7)); rfl_tag = $urandom_range(0, 1) ? TW'(20'hAAAAA) : TW'(20'h0B0B0);
    rfl_way = NW'(1) << $urandom_range(0, NW - 1); rfl_line = rline();
  endtask

  task automatic rand_lkp_fields();
    lkp_idx = IW'($urandom_range(0, 7)); lkp_tag = $urandom_range(0, 1) ? TW'(20'hAAAAA) : TW'(20'h0B0B0);
  endtask

  initial begin
    // reset held 3 cycles with a lookup pending, then the power-up sweep
    lkp_req = 1'b1;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      lkp_req = 1'($urandom); rand_lkp_fields();
      rfl_req = 1'($urandom); rand_rfl_fields();
      flush = (i == 20);
      step();
    end
    flush = 1'b0; lkp_req = 1'b0; rfl_req = 1'b0;
    step();

    // refill then hit / miss
    refill(5, 20'h12345, 4'b0010, {16{8'hA5}});
    lookup(5, 20'h12345);
    lookup(5, 20'h12346);
    step(2);

    // refill wins over a simultaneous lookup, then four back-to-back lookups
    rfl_req = 1'b1; rfl_idx = 7; rfl_tag = 20'hABCDE; rfl_way = 4'b0001; rfl_line = rline();
    lkp_req = 1'b1; lkp_idx = 7; lkp_tag = 20'hABCDE;
    step();
    rfl_req = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      lkp_idx = (i % 2 == 0) ? IW'(5) : IW'(7);
      lkp_tag = (i % 2 == 0) ? TW'(20'h12345) : TW'(20'hABCDE);
      step();
    end
    lkp_req = 1'b0;
    step(2);

    // lookup then refill of same set: response shows pre-refill contents
    lookup(5, 20'h12345);
    refill(5, 20'h55555, 4'b0010, rline());
    lookup(5, 20'h55555);
    step(2);

    // duplicate tag in two ways: lowest way reported
    refill(9, 20'h0BEEF, 4'b0001, rline());
    refill(9, 20'h0BEEF, 4'b0100, rline());
    lookup(9, 20'h0BEEF);
    step(2);

    // flush beats refill and lookup in the same cycle
    flush = 1'b1; rfl_req = 1'b1; rand_rfl_fields(); lkp_req = 1'b1; lkp_idx = 5; lkp_tag = 20'h55555;
    step();
    flush = 1'b0; rfl_req = 1'b0; lkp_req = 1'b0;
    step(NS);
    lookup(5, 20'h55555);
    step(2);

    // reset at set 30 restarts the sweep; mid-sweep flush is merged
    flush = 1'b1; step(); flush = 1'b0;
    step(30);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      flush = (i == 10);
      step();
    end
    flush = 1'b0;
    step(2);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      lkp_req = ($urandom_range(0, 3) != 0); rand_lkp_fields();
      rfl_req = ($urandom_range(0, 3) == 0); rand_rfl_fields();
      flush   = ($urandom_range(0, 99) == 0);
      step();
    end
    lkp_req = 1'b0; rfl_req = 1'b0; flush = 1'b0;
    step(NS + 8);

    @(negedge clk); #1;
    chk("scoreboard_drained", LW'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
